// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU among NREQ requesters
//   Ports: clk, rst (async, active-high)
//          req_valid/req_ready/req_in1/req_in2/req_op : per-requester request handshake (packed slices)
//          resp_valid/resp_ready : one-hot response handshake; resp_data/resp_flags shared result bus
//          busy : not IDLE
//          alu_in1/alu_in2/alu_op : registered ALU operands; alu_out/alu_zero/alu_lt/alu_ltu : ALU results
//   Optional: define ALU_ARB_FLAGS_EN to capture {ltu, lt, zero} into resp_flags (else tied to 0).
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_in1,
  input  logic [NREQ*32-1:0]  req_in2,
  input  logic [NREQ*3-1:0]   req_op,
  output logic [NREQ-1:0]     resp_valid,
  input  logic [NREQ-1:0]     resp_ready,
  output logic [31:0]         resp_data,
  output logic [2:0]          resp_flags,
  output logic                busy,
  output logic [31:0]         alu_in1,
  output logic [31:0]         alu_in2,
  output logic [2:0]          alu_op,
  input  logic [31:0]         alu_out,
  input  logic                alu_zero,
  input  logic                alu_lt,
  input  logic                alu_ltu
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t r_state;
  logic [IW-1:0] r_last, r_grant, w_win, w_idx;
  logic w_any;
  // search starts just after the last winner and wraps, so the first hit is the round-robin winner
  always_comb begin
    w_any = 1'b0;
    w_win = r_last;
    w_idx = r_last;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end
  assign req_ready = (r_state == IDLE && w_any) ? (NREQ'(1) << w_win) : '0;
  assign busy = r_state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= IW'(NREQ - 1);
      r_grant    <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= '0;
    end else
      case (r_state)
        IDLE: if (w_any) begin
          alu_in1 <= req_in1[w_win*32 +: 32];
          alu_in2 <= req_in2[w_win*32 +: 32];
          alu_op  <= req_op[w_win*3 +: 3];
          r_grant <= w_win;
          r_last  <= w_win;
          r_state <= ISSUE;
        end
        ISSUE: r_state <= CAPTURE;
        CAPTURE: begin
          resp_data  <= alu_out;
          resp_valid <= NREQ'(1) << r_grant;
          r_state    <= RESP;
        end
        RESP: if (resp_ready[r_grant]) begin
          resp_valid <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
`ifdef ALU_ARB_FLAGS_EN
  logic [2:0] r_flags;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_flags <= '0;
    else if (r_state == CAPTURE) r_flags <= {alu_ltu, alu_lt, alu_zero};
  assign resp_flags = r_flags;
`else
  logic w_unused_flags;
  assign w_unused_flags = ^{alu_zero, alu_lt, alu_ltu};
  assign resp_flags = 3'b000;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven and sequence checks of alu_arbiter against a bench ALU and scoreboard
module tb_alu_arbiter;
  localparam int N = 2;
`ifdef ALU_ARB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [N*32-1:0] req_in1 = '0, req_in2 = '0;
  logic [N*3-1:0] req_op = '0;
  logic [31:0] resp_data, alu_in1, alu_in2, alu_out;
  logic [2:0] resp_flags, alu_op;
  logic busy, alu_zero, alu_lt, alu_ltu;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_flags(resp_flags), .busy(busy), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu)
  );
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return $signed(a) >>> b[4:0];
    endcase
  endfunction
  always_ff @(posedge clk) begin
    alu_out  <= alu_f(alu_in1, alu_in2, alu_op);
    alu_zero <= alu_f(alu_in1, alu_in2, alu_op) == 32'd0;
    alu_lt   <= $signed(alu_in1) < $signed(alu_in2);
    alu_ltu  <= alu_in1 < alu_in2;
  end
  typedef struct {
    bit rst;
    logic [1:0] v;
    logic [31:0] a0, b0;
    logic [2:0] op0;
    logic [31:0] a1, b1;
    logic [2:0] op1;
    logic [1:0] grant;
    logic [31:0] data;
    logic [2:0] flags;
  } vec_t;
  typedef struct {
    logic [1:0] who;
    logic [31:0] data;
    logic [2:0] flags;
  } exp_t;
  exp_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic run_op(input vec_t t);
    exp_t e;
    int lat;
    if (t.rst) do_reset();
    req_valid = t.v;
    req_in1 = {t.a1, t.a0};
    req_in2 = {t.b1, t.b0};
    req_op = {t.op1, t.op0};
    @(negedge clk);
    chk("req_ready", req_ready, t.grant);
    sb.push_back('{t.grant, t.data, FLAGS ? t.flags : 3'b000});
    @(posedge clk);
    #1 req_valid = '0;
    chk("busy_issue", busy, 1);
    chk("alu_in1", alu_in1, t.grant[1] ? t.a1 : t.a0);
    chk("alu_in2", alu_in2, t.grant[1] ? t.b1 : t.b0);
    chk("alu_op", alu_op, t.grant[1] ? t.op1 : t.op0);
    lat = 0;
    while (resp_valid == '0 && lat < 8) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, 2);
    e = sb.pop_front();
    chk("resp_valid", resp_valid, e.who);
    chk("resp_data", resp_data, e.data);
    chk("resp_flags", resp_flags, e.flags);
    resp_ready = e.who;
    @(posedge clk);
    #1 resp_ready = '0;
    chk("resp_valid_clr", resp_valid, 0);
    chk("busy_done", busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl[10];
    exp_t e;
    int lat;
    tbl = '{
      '{1, 2'b01, 32'd5, 32'd3, 3'd0, 32'd0, 32'd0, 3'd0, 2'b01, 32'd8, 3'b000},
      '{1, 2'b11, 32'd1, 32'd1, 3'd0, 32'd1, 32'd1, 3'd0, 2'b01, 32'd2, 3'b000},
      '{0, 2'b11, 32'd1, 32'd1, 3'd0, 32'd1, 32'd1, 3'd0, 2'b10, 32'd2, 3'b000},
      '{0, 2'b11, 32'd1, 32'd1, 3'd0, 32'd1, 32'd1, 3'd0, 2'b01, 32'd2, 3'b000},
      '{0, 2'b11, 32'd1, 32'd1, 3'd0, 32'd1, 32'd1, 3'd0, 2'b10, 32'd2, 3'b000},
      '{0, 2'b01, 32'd3, 32'd5, 3'd1, 32'd0, 32'd0, 3'd0, 2'b01, 32'hFFFFFFFE, 3'b110},
      '{0, 2'b10, 32'd0, 32'd0, 3'd0, 32'd7, 32'd7, 3'd1, 2'b10, 32'd0, 3'b001},
      '{0, 2'b10, 32'd0, 32'd0, 3'd0, 32'h80000000, 32'd4, 3'd7, 2'b10, 32'hF8000000, 3'b010},
      '{0, 2'b11, 32'hF0F0, 32'h0FF0, 3'd4, 32'd1, 32'd31, 3'd5, 2'b01, 32'h0000FF00, 3'b000},
      '{0, 2'b11, 32'hF0F0, 32'h0FF0, 3'd4, 32'd1, 32'd31, 3'd5, 2'b10, 32'h80000000, 3'b110}
    };
    do_reset();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_flags", resp_flags, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_in2", alu_in2, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    for (int i = 0; i < 10; i++) run_op(tbl[i]);
    // response held while resp_ready is low; the other requester's resp_ready is ignored
    do_reset();
    req_valid = 2'b01;
    req_in1 = {32'd0, 32'd2};
    req_in2 = {32'd0, 32'd2};
    req_op = '0;
    @(negedge clk);
    chk("t3_ready", req_ready, 2'b01);
    sb.push_back('{2'b01, 32'd4, 3'b000});
    @(posedge clk);
    #1 req_valid = 2'b11;
    resp_ready = 2'b10;
    lat = 0;
    while (resp_valid == '0 && lat < 8) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("t3_latency", lat, 2);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", resp_valid, e.who);
      chk("t3_hold_data", resp_data, e.data);
      chk("t3_hold_ready", req_ready, 0);
      chk("t3_hold_busy", busy, 1);
      @(posedge clk);
      #1;
    end
    resp_ready = 2'b01;
    @(negedge clk);
    chk("t3_no_accept_on_resp", req_ready, 0);
    @(posedge clk);
    #1 resp_ready = '0;
    chk("t3_resp_clr", resp_valid, 0);
    chk("t3_next_grant", req_ready, 2'b10);
    req_valid = '0;
    // reset during CAPTURE drops the op and restores round-robin start
    do_reset();
    req_valid = 2'b11;
    req_in1 = {32'd9, 32'd9};
    req_in2 = {32'd1, 32'd1};
    req_op = '0;
    @(negedge clk);
    chk("t4_ready", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1 chk("t4_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("t4_resp_valid", resp_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_alu_in1", alu_in1, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 chk("t4_no_resp", resp_valid, 0);
    end
    run_op('{0, 2'b11, 32'd9, 32'd1, 3'd0, 32'd9, 32'd1, 3'd0, 2'b01, 32'd10, 3'b000});
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
